matrix_scan_ctrl: RTL

- Sequences one HUB75-style LED panel using binary-coded modulation (BCM).
- Walks rows and bit planes, fetches pixels from the framebuffer, and drives the brightness mask and colour enables of the pixel splitter datapath.
- Generates the panel shift clock, latch, output-enable and row address.
- Handles a double-buffer swap handshake at frame boundaries.

---
 rtl/matrix_scan_ctrl_if.sv | 34 +++
 rtl/matrix_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl_if.sv
// Framebuffer, swap-handshake and panel signals of the HUB75 BCM scan controller.
// The master side is the controller; the slave side is the framebuffer/panel/host.
interface matrix_scan_ctrl_if #(
    parameter int COLS      = 64,
    parameter int ROW_BITS  = 4,
    parameter int BIT_DEPTH = 6
);
    localparam int COL_W = $clog2(COLS);

    logic                 enable;
    logic                 swap_req;
    logic                 swap_ack;
    logic                 fb_select;
    logic [COL_W-1:0]     col_addr;
    logic [ROW_BITS-1:0]  row_addr;
    logic [BIT_DEPTH-1:0] brightness_mask;
    logic [2:0]           rgb_enable;
    logic                 panel_clk;
    logic                 panel_latch;
    logic                 panel_oe_n;
    logic                 frame_done;

    modport master (
        input  enable, swap_req,
        output swap_ack, fb_select, col_addr, row_addr, brightness_mask,
               rgb_enable, panel_clk, panel_latch, panel_oe_n, frame_done
    );

    modport slave (
        output enable, swap_req,
        input  swap_ack, fb_select, col_addr, row_addr, brightness_mask,
               rgb_enable, panel_clk, panel_latch, panel_oe_n, frame_done
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// HUB75 panel sequencer with binary-coded modulation: shift a row, blank, latch,
// light it for BASE_TIME<<plane cycles, then move to the next plane/row; swaps buffers at frame end.
module matrix_scan_ctrl #(
    parameter int COLS      = 64,
    parameter int ROW_BITS  = 4,
    parameter int BIT_DEPTH = 6,
    parameter int BASE_TIME = 8
) (
    input  logic               clk,
    input  logic               reset,
    matrix_scan_ctrl_if.master bus
);
    localparam int COL_W    = $clog2(COLS);
    localparam int SHOW_MAX = BASE_TIME << (BIT_DEPTH - 1);
    localparam int CNT_W    = $clog2(SHOW_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        BLANK = 3'd2,
        LATCH = 3'd3,
        SHOW  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [1:0]           phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, plane_len_s;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [BIT_DEPTH-1:0] mask_q, mask_d;
    logic                 fb_q, fb_d;
    logic                 frame_done_q, frame_done_d;
    logic                 swap_ack_q, swap_ack_d;
    logic                 panel_clk_q, panel_clk_d;
    logic                 latch_q, latch_d;
    logic                 oe_n_q, oe_n_d;
    logic [2:0]           rgb_q, rgb_d;
    logic                 plane_end_s, frame_end_s;

    // Display length of the current plane, selected by the one-hot mask.
    always_comb begin
        plane_len_s = '0;
        for (int i = 0; i < BIT_DEPTH; i++) begin
            plane_len_s = mask_q[i] ? CNT_W'(BASE_TIME << i) : plane_len_s;
        end
    end

    // Next-state sequencing and registered-output decode.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        mask_d       = mask_q;
        fb_d         = fb_q;
        plane_end_s  = (state_q == SHOW) && (cnt_q == '0);
        frame_end_s  = plane_end_s && mask_q[BIT_DEPTH-1] && (row_q == '1);
        frame_done_d = frame_end_s;
        swap_ack_d   = frame_end_s && bus.swap_req;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = SHIFT;
                    col_d   = '0;
                    phase_d = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = BLANK;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            BLANK: state_d = LATCH;
            LATCH: begin
                state_d = SHOW;
                cnt_d   = plane_len_s - CNT_W'(1);
            end
            SHOW: begin
                if (plane_end_s) begin
                    // Rotating the top plane wraps the mask back to plane 0.
                    mask_d  = {mask_q[BIT_DEPTH-2:0], mask_q[BIT_DEPTH-1]};
                    row_d   = mask_q[BIT_DEPTH-1] ? row_q + ROW_BITS'(1) : row_q;
                    fb_d    = swap_ack_d ? ~fb_q : fb_q;
                    col_d   = '0;
                    phase_d = 2'd0;
                    state_d = bus.enable ? SHIFT : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        panel_clk_d = (state_d == SHIFT) && (phase_d == 2'd2);
        rgb_d       = ((state_d == SHIFT) && (phase_d != 2'd0)) ? 3'b111 : 3'b000;
        latch_d     = (state_d == LATCH);
        oe_n_d      = (state_d != SHOW);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            phase_q      <= 2'd0;
            cnt_q        <= '0;
            row_q        <= '0;
            mask_q       <= BIT_DEPTH'(1);
            fb_q         <= 1'b0;
            frame_done_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            panel_clk_q  <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            rgb_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            mask_q       <= mask_d;
            fb_q         <= fb_d;
            frame_done_q <= frame_done_d;
            swap_ack_q   <= swap_ack_d;
            panel_clk_q  <= panel_clk_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            rgb_q        <= rgb_d;
        end
    end

    assign bus.col_addr        = col_q;
    assign bus.row_addr        = row_q;
    assign bus.brightness_mask = mask_q;
    assign bus.rgb_enable      = rgb_q;
    assign bus.panel_clk       = panel_clk_q;
    assign bus.panel_latch     = latch_q;
    assign bus.panel_oe_n      = oe_n_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.swap_ack        = swap_ack_q;
    assign bus.fb_select       = fb_q;
endmodule
